// File: rtl/ordered_merge_fsm_pkg.sv
// Shared definitions for the ordered merge controller: one-hot state encoding.
package ordered_merge_fsm_pkg;

  localparam int ST_W = 5;

  // One-hot state constants; any other encoding is treated as illegal.
  localparam logic [ST_W-1:0] ST_INIT      = 5'b00001;
  localparam logic [ST_W-1:0] ST_WAIT_DATA = 5'b00010;
  localparam logic [ST_W-1:0] ST_PUSH      = 5'b00100;
  localparam logic [ST_W-1:0] ST_OF_FULL   = 5'b01000;
  localparam logic [ST_W-1:0] ST_ERROR     = 5'b10000;

endpackage

// File: rtl/ordered_merge_match.sv
// Head-index comparator and priority encoder for the ordered merge controller.
// A channel whose head equals the current index beats any channel holding the
// next index; within a class the lowest channel number wins.
module ordered_merge_match #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 10,
  parameter int CH_W   = 3
) (
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic [NUM_CH-1:0]       ch_valid,
  input  logic [NUM_CH*IDX_W-1:0] ch_index_q,
  input  logic [IDX_W-1:0]        cur_index,
  output logic                    hit,
  output logic                    hit_inc,
  output logic [CH_W-1:0]         hit_ch
);

  logic [IDX_W-1:0]  nxt_index;
  logic [NUM_CH-1:0] live;
  logic [NUM_CH-1:0] eq_cur;
  logic [NUM_CH-1:0] eq_nxt;

  // Next index wraps naturally at 2**IDX_W.
  assign nxt_index = cur_index + IDX_W'(1);
  assign live      = ch_mask & ch_valid;

  // Per-channel compare against the current and the next output index.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    eq_cur = '0;
    eq_nxt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      eq_cur[c] = live[c] && (ch_index_q[c*IDX_W +: IDX_W] == cur_index);
      eq_nxt[c] = live[c] && (ch_index_q[c*IDX_W +: IDX_W] == nxt_index);
    end
  end

  // Priority pick: scan high to low so the lowest matching channel is the last write.
  always_comb begin
    hit     = (|eq_cur) || (|eq_nxt);
    hit_inc = !(|eq_cur) && (|eq_nxt);
    hit_ch  = '0;
    if (|eq_cur) begin
      for (int c = NUM_CH-1; c >= 0; c--) begin
        if (eq_cur[c]) hit_ch = CH_W'(c);
      end
    end else begin
      for (int c = NUM_CH-1; c >= 0; c--) begin
        if (eq_nxt[c]) hit_ch = CH_W'(c);
      end
    end
  end

endmodule

// File: rtl/ordered_merge_fsm.sv
// N-channel in-order merge controller. Pushes channel heads into a shared
// output FIFO in ascending field-index order, with backpressure, a soft
// clear, sticky order-error detection and a saturating push counter.
// All outputs decode from registered state only.
module ordered_merge_fsm
  import ordered_merge_fsm_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 10,
  parameter int CH_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    soft_clr,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic [NUM_CH-1:0]       ch_valid,
  input  logic [NUM_CH*IDX_W-1:0] ch_index_q,
  output logic [NUM_CH-1:0]       ch_accepted,
  output logic [NUM_CH-1:0]       ch_enable,
  input  logic                    out_fifo_full,
  output logic                    out_fifo_clr,
  output logic                    out_fifo_push,
  output logic [IDX_W-1:0]        out_index,
  output logic                    order_err,
  output logic [CNT_W-1:0]        push_count
);

  logic [ST_W-1:0]   state;
  logic [ST_W-1:0]   next_state;
  logic [CH_W-1:0]   sel;
  logic [CH_W-1:0]   next_sel;
  logic              inc;
  logic              next_inc;
  logic [1:0]        rst_sync;
  logic              run;
  logic              hit;
  logic              hit_inc;
  logic [CH_W-1:0]   hit_ch;
  logic              stall_err;
  logic [NUM_CH-1:0] sel_oh;

  ordered_merge_match #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W),
    .CH_W   (CH_W)
  ) u_match (
    .ch_mask    (ch_mask),
    .ch_valid   (ch_valid),
    .ch_index_q (ch_index_q),
    .cur_index  (out_index),
    .hit        (hit),
    .hit_inc    (hit_inc),
    .hit_ch     (hit_ch)
  );

  // Deadlock: every participating channel shows a head, yet none is usable.
  assign stall_err = (ch_mask != '0) && ((ch_valid & ch_mask) == ch_mask);

  // Reset release synchroniser: the FSM leaves INIT only once run is high.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  // State, selected channel and increment flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_INIT;
      sel   <= '0;
      inc   <= 1'b0;
    end else begin
      state <= next_state;
      sel   <= next_sel;
      inc   <= next_inc;
    end
  end

  // Next-state logic; soft_clr overrides every other transition.
  always_comb begin
    next_state = state;
    next_sel   = sel;
    next_inc   = inc;
    case (state)
      ST_INIT: begin
        if (run) next_state = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (!hit && stall_err) begin
          next_state = ST_ERROR;
        end else if (hit) begin
          next_sel   = hit_ch;
          next_inc   = hit_inc;
          next_state = out_fifo_full ? ST_OF_FULL : ST_PUSH;
        end
      end
      ST_OF_FULL: begin
        if (!out_fifo_full) next_state = ST_PUSH;
      end
      ST_PUSH:  next_state = ST_WAIT_DATA;
      ST_ERROR: next_state = ST_ERROR;
      default:  next_state = ST_INIT;
    endcase
    if (soft_clr) next_state = ST_INIT;
  end

  // Output index and saturating push counter, cleared while in INIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_index  <= '0;
      push_count <= '0;
    end else if (state == ST_INIT) begin
      out_index  <= '0;
      push_count <= '0;
    end else if (state == ST_PUSH) begin
      if (inc) out_index <= out_index + IDX_W'(1);
      if (push_count != '1) push_count <= push_count + CNT_W'(1);
    end
  end

  // One-hot decode of the latched channel select.
  always_comb begin
    sel_oh = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_oh[c] = (sel == CH_W'(c));
    end
  end

  assign out_fifo_push = (state == ST_PUSH);
  assign ch_enable     = out_fifo_push ? sel_oh : '0;
  assign ch_accepted   = out_fifo_push ? sel_oh : '0;
  assign out_fifo_clr  = run && (state == ST_INIT);
  assign order_err     = (state == ST_ERROR);

endmodule

// File: tb/tb_ordered_merge_fsm.sv
// Directed bench for ordered_merge_fsm: 3 channels, 4-bit index.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ordered_merge_fsm;

  localparam int NUM_CH = 3;
  localparam int IDX_W  = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 16;

  logic                    clk;
  logic                    reset_n;
  logic                    soft_clr;
  logic [NUM_CH-1:0]       ch_mask;
  logic [NUM_CH-1:0]       ch_valid;
  logic [NUM_CH*IDX_W-1:0] ch_index_q;
  logic [NUM_CH-1:0]       ch_accepted;
  logic [NUM_CH-1:0]       ch_enable;
  logic                    out_fifo_full;
  logic                    out_fifo_clr;
  logic                    out_fifo_push;
  logic [IDX_W-1:0]        out_index;
  logic                    order_err;
  logic [CNT_W-1:0]        push_count;

  int n_checks = 0;
  int n_errors = 0;

  // Bench-side model of the index and push counter.
  logic [IDX_W-1:0] model_idx;
  logic [CNT_W-1:0] model_cnt;

  typedef struct packed {
    logic [2:0] mask;
    logic [2:0] valid;
    logic [3:0] off0;   // head index offsets relative to the current out_index
    logic [3:0] off1;
    logic [3:0] off2;
    logic [2:0] acc;    // expected ch_accepted one-hot (0 = no push)
    logic       inc;    // expected index increment
  } vec_t;

  vec_t vecs [10];

  ordered_merge_fsm #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W),
    .CH_W   (CH_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .soft_clr      (soft_clr),
    .ch_mask       (ch_mask),
    .ch_valid      (ch_valid),
    .ch_index_q    (ch_index_q),
    .ch_accepted   (ch_accepted),
    .ch_enable     (ch_enable),
    .out_fifo_full (out_fifo_full),
    .out_fifo_clr  (out_fifo_clr),
    .out_fifo_push (out_fifo_push),
    .out_index     (out_index),
    .order_err     (order_err),
    .push_count    (push_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present heads at a falling edge, verify the push one cycle later, then
  // drop the heads and verify the datapath update.
  task automatic try_push(input string name, input logic [2:0] m, input logic [2:0] v,
                          input logic [3:0] i0, input logic [3:0] i1, input logic [3:0] i2,
                          input logic [2:0] exp_acc, input logic exp_inc);
    ch_mask    = m;
    ch_valid   = v;
    ch_index_q = {i2, i1, i0};
    @(negedge clk);
    check({name, " accepted"}, 32'(ch_accepted), 32'(exp_acc));
    check({name, " enable"}, 32'(ch_enable), 32'(exp_acc));
    check({name, " push"}, 32'(out_fifo_push), 32'(|exp_acc));
    ch_valid = '0;
    if (|exp_acc) begin
      model_cnt = model_cnt + 1'b1;
      if (exp_inc) model_idx = model_idx + 1'b1;
    end
    @(negedge clk);
    check({name, " out_index"}, 32'(out_index), 32'(model_idx));
    check({name, " push_count"}, 32'(push_count), 32'(model_cnt));
    check({name, " order_err"}, 32'(order_err), 32'd0);
  endtask

  // Pulse soft_clr and expect a single clear cycle followed by WAIT_DATA.
  task automatic do_soft_clr(input string name);
    soft_clr = 1'b1;
    ch_valid = '0;
    @(negedge clk);
    soft_clr = 1'b0;
    check({name, " clr pulse"}, 32'(out_fifo_clr), 32'd1);
    check({name, " order_err cleared"}, 32'(order_err), 32'd0);
    @(negedge clk);
    check({name, " clr low"}, 32'(out_fifo_clr), 32'd0);
    check({name, " index zero"}, 32'(out_index), 32'd0);
    check({name, " count zero"}, 32'(push_count), 32'd0);
    model_idx = '0;
    model_cnt = '0;
  endtask

  initial begin
    int clr_cycles;
    logic [3:0] base;

    //           mask    valid   off0   off1   off2   acc     inc
    vecs[0] = '{3'b111, 3'b001, 4'd0,  4'd7,  4'd7,  3'b001, 1'b0}; // single cur
    vecs[1] = '{3'b111, 3'b010, 4'd7,  4'd1,  4'd7,  3'b010, 1'b1}; // single nxt
    vecs[2] = '{3'b111, 3'b011, 4'd1,  4'd0,  4'd7,  3'b010, 1'b0}; // cur beats lower nxt
    vecs[3] = '{3'b111, 3'b111, 4'd1,  4'd1,  4'd1,  3'b001, 1'b1}; // lowest nxt wins
    vecs[4] = '{3'b111, 3'b110, 4'd0,  4'd0,  4'd0,  3'b010, 1'b0}; // lowest valid cur
    vecs[5] = '{3'b101, 3'b111, 4'd5,  4'd0,  4'd1,  3'b100, 1'b1}; // masked ch1 ignored
    vecs[6] = '{3'b011, 3'b001, 4'd3,  4'd7,  4'd0,  3'b000, 1'b0}; // no match, not all valid
    vecs[7] = '{3'b000, 3'b111, 4'd0,  4'd0,  4'd0,  3'b000, 1'b0}; // all masked out
    vecs[8] = '{3'b100, 3'b100, 4'd7,  4'd7,  4'd1,  3'b100, 1'b1}; // only ch2
    vecs[9] = '{3'b111, 3'b101, 4'd1,  4'd7,  4'd1,  3'b001, 1'b1}; // tie, lowest

    reset_n       = 1'b0;
    soft_clr      = 1'b0;
    ch_mask       = 3'b011;
    ch_valid      = '0;
    ch_index_q    = '0;
    out_fifo_full = 1'b0;
    model_idx     = '0;
    model_cnt     = '0;

    // T1: outputs quiet during reset, then exactly one clear cycle.
    @(negedge clk);
    @(negedge clk);
    check("reset clr", 32'(out_fifo_clr), 32'd0);
    check("reset push", 32'(out_fifo_push), 32'd0);
    check("reset accepted", 32'(ch_accepted), 32'd0);
    check("reset enable", 32'(ch_enable), 32'd0);
    check("reset order_err", 32'(order_err), 32'd0);
    check("reset out_index", 32'(out_index), 32'd0);
    check("reset push_count", 32'(push_count), 32'd0);
    reset_n = 1'b1;
    clr_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_fifo_clr) begin
        clr_cycles++;
        check("t1 index at clr", 32'(out_index), 32'd0);
        check("t1 push at clr", 32'(out_fifo_push), 32'd0);
      end
    end
    check("t1 clr cycles", 32'(clr_cycles), 32'd1);
    check("t1 order_err", 32'(order_err), 32'd0);

    // Table-driven selection vectors.
    for (int k = 0; k < 10; k++) begin
      base = model_idx;
      try_push($sformatf("vec%0d", k), vecs[k].mask, vecs[k].valid,
               base + vecs[k].off0, base + vecs[k].off1, base + vecs[k].off2,
               vecs[k].acc, vecs[k].inc);
    end

    // T2: interleave ch0 idx0, ch1 idx1, ch0 idx1.
    do_soft_clr("t2 clr");
    try_push("t2 ch0 idx0", 3'b011, 3'b001, 4'd0, 4'd0, 4'd0, 3'b001, 1'b0);
    try_push("t2 ch1 idx1", 3'b011, 3'b010, 4'd0, 4'd1, 4'd0, 3'b010, 1'b1);
    try_push("t2 ch0 idx1", 3'b011, 3'b001, 4'd1, 4'd1, 4'd0, 3'b001, 1'b0);
    check("t2 push_count", 32'(push_count), 32'd3);

    // T3: advance to index 4, then ch0 idx5 vs ch2 idx4.
    try_push("t3 step2", 3'b111, 3'b001, 4'd2, 4'd0, 4'd0, 3'b001, 1'b1);
    try_push("t3 step3", 3'b111, 3'b001, 4'd3, 4'd0, 4'd0, 3'b001, 1'b1);
    try_push("t3 step4", 3'b111, 3'b001, 4'd4, 4'd0, 4'd0, 3'b001, 1'b1);
    ch_mask    = 3'b111;
    ch_valid   = 3'b101;
    ch_index_q = {4'd4, 4'd0, 4'd5};
    @(negedge clk);
    check("t3 first accept", 32'(ch_accepted), 32'b100);
    ch_valid = 3'b001;
    @(negedge clk);
    check("t3 gap push", 32'(out_fifo_push), 32'd0);
    check("t3 no inc on ch2", 32'(out_index), 32'd4);
    @(negedge clk);
    check("t3 second accept", 32'(ch_accepted), 32'b001);
    ch_valid  = '0;
    model_cnt = model_cnt + 2'd2;
    model_idx = 4'd5;
    @(negedge clk);
    check("t3 out_index", 32'(out_index), 32'd5);
    check("t3 push_count", 32'(push_count), 32'(model_cnt));

    // T4: backpressure for 7 cycles, push one cycle after full drops.
    out_fifo_full = 1'b1;
    ch_valid      = 3'b010;
    ch_index_q    = {4'd0, 4'd5, 4'd0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("t4 held push c%0d", i), 32'(out_fifo_push), 32'd0);
    end
    out_fifo_full = 1'b0;
    @(negedge clk);
    check("t4 push after release", 32'(out_fifo_push), 32'd1);
    check("t4 accepted", 32'(ch_accepted), 32'b010);
    ch_valid  = '0;
    model_cnt = model_cnt + 1'b1;
    @(negedge clk);
    check("t4 out_index", 32'(out_index), 32'(model_idx));
    check("t4 push_count", 32'(push_count), 32'(model_cnt));

    // T5: climb to index 15, then ch1 idx0 wraps to 0.
    for (int i = 0; i < 16 && model_idx != 4'd15; i++) begin
      base = model_idx + 1'b1;
      try_push("t5 climb", 3'b111, 3'b010, 4'd9, base, 4'd9, 3'b010, 1'b1);
    end
    check("t5 at 15", 32'(out_index), 32'd15);
    try_push("t5 wrap", 3'b111, 3'b010, 4'd9, 4'd0, 4'd9, 3'b010, 1'b1);
    check("t5 wrapped index", 32'(out_index), 32'd0);

    // A push cycle coincident with soft_clr still completes; INIT follows.
    ch_valid   = 3'b001;
    ch_index_q = {4'd0, 4'd0, 4'd0};
    @(negedge clk);
    soft_clr = 1'b1;
    ch_valid = '0;
    check("clr in push: push", 32'(out_fifo_push), 32'd1);
    check("clr in push: accepted", 32'(ch_accepted), 32'b001);
    @(negedge clk);
    soft_clr = 1'b0;
    check("clr in push: clr", 32'(out_fifo_clr), 32'd1);
    @(negedge clk);
    check("clr in push: count", 32'(push_count), 32'd0);
    model_idx = '0;
    model_cnt = '0;

    // T6: all channels stuck at out_index+3 -> sticky error, then soft clear.
    ch_mask    = 3'b111;
    ch_valid   = 3'b111;
    ch_index_q = {4'd3, 4'd3, 4'd3};
    @(negedge clk);
    check("t6 order_err set", 32'(order_err), 32'd1);
    check("t6 no push", 32'(out_fifo_push), 32'd0);
    ch_index_q = {4'd0, 4'd0, 4'd0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t6 sticky c%0d", i), 32'(order_err), 32'd1);
      check($sformatf("t6 no push c%0d", i), 32'(out_fifo_push), 32'd0);
    end
    do_soft_clr("t6 clr");
    check("t6 order_err after clr", 32'(order_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
